// File: rtl/pwm_driver.sv
// pwm_driver
//   Turns the signed controller command into a glitch-free PWM waveform plus a
//   direction bit for the motor bridge. The duty is sampled only at period
//   boundaries. The period and deadband registers are shadowed and take effect
//   at the next wrap. CTRL takes effect immediately.
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-high reset, clears all state
//   write_enable  in   register write strobe
//   reg_addr      in   register select (0 PERIOD, 1 DEADBAND, 2 CTRL)
//   reg_data      in   register write data
//   duty_in       in   signed two's-complement duty command
//   pwm_out       out  registered PWM drive
//   dir_out       out  registered direction (1 = negative command, after invert)
//   period_start  out  one-cycle pulse on the first cycle of each period
module pwm_driver #(
    parameter int unsigned D_WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               write_enable,
    input  logic [15:0]        reg_addr,
    input  logic [D_WIDTH-1:0] reg_data,
    input  logic [D_WIDTH-1:0] duty_in,
    output logic               pwm_out,
    output logic               dir_out,
    output logic               period_start
);

    localparam logic [D_WIDTH-1:0] ONE     = {{(D_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [D_WIDTH-1:0] MAG_MAX = {1'b0, {(D_WIDTH-1){1'b1}}};

    localparam logic [15:0] ADDR_PERIOD   = 16'd0;
    localparam logic [15:0] ADDR_DEADBAND = 16'd1;
    localparam logic [15:0] ADDR_CTRL     = 16'd2;

    // Shadow / control registers
    logic [D_WIDTH-1:0] period_reg;
    logic [D_WIDTH-1:0] deadband_reg;
    logic               enable;
    logic               dir_invert;

    // Active per-period state. Deadband is only consulted while sampling the
    // duty at a wrap edge, and that sampling uses the shadow register, so no
    // active copy of it is kept.
    logic [D_WIDTH-1:0] cnt;
    logic [D_WIDTH-1:0] per_act;
    logic [D_WIDTH-1:0] duty_act;
    logic               dir_act;

    // Next-state values
    logic               wrap;
    logic [D_WIDTH-1:0] abs_val;
    logic [D_WIDTH-1:0] mag_sat;
    logic [D_WIDTH-1:0] mag;
    logic [D_WIDTH-1:0] cnt_next;
    logic [D_WIDTH-1:0] per_act_next;
    logic [D_WIDTH-1:0] duty_act_next;
    logic               dir_act_next;

    // Register bus
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_reg   <= '0;
            deadband_reg <= '0;
            enable       <= 1'b0;
            dir_invert   <= 1'b0;
        end else if (write_enable) begin
            case (reg_addr)
                ADDR_PERIOD:   period_reg   <= reg_data;
                ADDR_DEADBAND: deadband_reg <= reg_data;
                ADDR_CTRL: begin
                    enable     <= reg_data[0];
                    dir_invert <= reg_data[1];
                end
                default: ;
            endcase
        end
    end

    // Magnitude of the command: the most negative value has no positive
    // counterpart, so it saturates to the largest positive magnitude.
    always_comb begin
        abs_val = duty_in[D_WIDTH-1] ? ((~duty_in) + ONE) : duty_in;
        mag_sat = abs_val[D_WIDTH-1] ? MAG_MAX : abs_val;
        if (mag_sat < deadband_reg) begin
            mag = '0;
        end else if (mag_sat > period_reg) begin
            mag = period_reg;
        end else begin
            mag = mag_sat;
        end
    end

    // A zero active period reloads on every edge, so it is treated as a wrap.
    always_comb begin
        wrap = (per_act == '0) || (cnt == (per_act - ONE));
        if (wrap) begin
            cnt_next      = '0;
            per_act_next  = period_reg;
            duty_act_next = mag;
            dir_act_next  = duty_in[D_WIDTH-1] && (mag != '0);
        end else begin
            cnt_next      = cnt + ONE;
            per_act_next  = per_act;
            duty_act_next = duty_act;
            dir_act_next  = dir_act;
        end
    end

    // Outputs are computed from next-state values so the waveform lines up
    // with the counter: duty_act high cycles starting at cnt == 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            per_act      <= '0;
            duty_act     <= '0;
            dir_act      <= 1'b0;
            pwm_out      <= 1'b0;
            dir_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            per_act      <= per_act_next;
            duty_act     <= duty_act_next;
            dir_act      <= dir_act_next;
            pwm_out      <= enable && (cnt_next < duty_act_next) && (per_act_next != '0);
            dir_out      <= dir_act_next ^ dir_invert;
            period_start <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_driver.sv
// tb_pwm_driver
//   Directed bench for pwm_driver: a table of register settings and duty
//   commands with hand-computed high-cycle counts, period lengths and
//   direction, plus hand-written sequences for reset, mid-period updates,
//   writes on the wrap edge, immediate CTRL changes and zero period.
module tb_pwm_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic        write_enable;
    logic [15:0] reg_addr;
    logic [15:0] reg_data;
    logic [15:0] duty_in;
    logic        pwm_out;
    logic        dir_out;
    logic        period_start;

    int checks = 0;
    int errors = 0;

    pwm_driver #(.D_WIDTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .write_enable (write_enable),
        .reg_addr     (reg_addr),
        .reg_data     (reg_data),
        .duty_in      (duty_in),
        .pwm_out      (pwm_out),
        .dir_out      (dir_out),
        .period_start (period_start)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [15:0] period;
        logic [15:0] deadband;
        logic [15:0] ctrl;
        logic [15:0] duty;
        int          exp_hi;
        int          exp_len;
        int          exp_dir;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Called at a negedge; drives the write for exactly one rising edge.
    task automatic write_reg(input logic [15:0] addr, input logic [15:0] data);
        write_enable = 1'b1;
        reg_addr     = addr;
        reg_data     = data;
        @(negedge clock);
        write_enable = 1'b0;
    endtask

    // Measures one full period starting at the next period_start (or the
    // current cycle if it is already a start). Ends at the negedge where the
    // following period_start is visible, so back-to-back calls measure
    // consecutive periods. len = -1 if no start arrives in time.
    task automatic measure(output int hi, output int len, output int dir, output int bad);
        int wait_cnt;
        bit seen_low;
        hi       = 0;
        len      = 0;
        dir      = 0;
        bad      = 0;
        seen_low = 1'b0;
        wait_cnt = 0;
        while (!period_start && wait_cnt < 200) begin
            @(negedge clock);
            wait_cnt++;
        end
        if (!period_start) begin
            len = -1;
            return;
        end
        dir = int'(dir_out);
        do begin
            if (pwm_out) begin
                hi++;
                if (seen_low) bad = 1;
            end else begin
                seen_low = 1'b1;
            end
            len++;
            @(negedge clock);
        end while (!period_start && len < 200);
    endtask

    initial begin
        int hi, len, dir, bad;

        vecs[0]  = '{"t1_basic",      16'd10, 16'd0, 16'd1, 16'd4,      4, 10, 0};
        vecs[1]  = '{"t2_neg",        16'd10, 16'd0, 16'd1, 16'hFFFD,   3, 10, 1};
        vecs[2]  = '{"t2_inv_neg",    16'd10, 16'd0, 16'd3, 16'hFFFD,   3, 10, 0};
        vecs[3]  = '{"inv_pos",       16'd10, 16'd0, 16'd3, 16'd4,      4, 10, 1};
        vecs[4]  = '{"t3_over",       16'd10, 16'd0, 16'd1, 16'd25,    10, 10, 0};
        vecs[5]  = '{"t3_most_neg",   16'd10, 16'd0, 16'd1, 16'h8000,  10, 10, 1};
        vecs[6]  = '{"max_pos",       16'd10, 16'd0, 16'd1, 16'h7FFF,  10, 10, 0};
        vecs[7]  = '{"eq_period",     16'd10, 16'd0, 16'd1, 16'd10,    10, 10, 0};
        vecs[8]  = '{"t4_below_db",   16'd10, 16'd5, 16'd1, 16'd4,      0, 10, 0};
        vecs[9]  = '{"t4_at_db",      16'd10, 16'd5, 16'd1, 16'd5,      5, 10, 0};
        vecs[10] = '{"neg_below_db",  16'd10, 16'd5, 16'd1, 16'hFFFC,   0, 10, 0};
        vecs[11] = '{"disabled",      16'd10, 16'd0, 16'd0, 16'd4,      0, 10, 0};
        vecs[12] = '{"zero_duty",     16'd10, 16'd0, 16'd1, 16'd0,      0, 10, 0};
        vecs[13] = '{"period20",      16'd20, 16'd0, 16'd1, 16'd7,      7, 20, 0};
        vecs[14] = '{"period1",       16'd1,  16'd0, 16'd1, 16'd1,      1,  1, 0};
        vecs[15] = '{"neg_one",       16'd10, 16'd0, 16'd1, 16'hFFFF,   1, 10, 1};

        reset        = 1'b1;
        write_enable = 1'b0;
        reg_addr     = '0;
        reg_data     = '0;
        duty_in      = '0;
        #1;
        check("reset_pwm",   int'(pwm_out), 0);
        check("reset_dir",   int'(dir_out), 0);
        check("reset_start", int'(period_start), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Zero period after reset: reload every cycle, no drive.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("p0_start", int'(period_start), 1);
            check("p0_pwm",   int'(pwm_out), 0);
        end

        // Table: program, skip one period to let the shadows settle, measure.
        foreach (vecs[i]) begin
            write_reg(16'd2, vecs[i].ctrl);
            write_reg(16'd1, vecs[i].deadband);
            write_reg(16'd0, vecs[i].period);
            duty_in = vecs[i].duty;
            measure(hi, len, dir, bad);
            measure(hi, len, dir, bad);
            check({vecs[i].name, "_hi"},    hi,  vecs[i].exp_hi);
            check({vecs[i].name, "_len"},   len, vecs[i].exp_len);
            check({vecs[i].name, "_dir"},   dir, vecs[i].exp_dir);
            check({vecs[i].name, "_shape"}, bad, 0);
        end

        // Mid-period duty and PERIOD change: current period unaffected.
        write_reg(16'd1, 16'd0);
        write_reg(16'd2, 16'd1);
        write_reg(16'd0, 16'd10);
        duty_in = 16'd4;
        measure(hi, len, dir, bad);
        measure(hi, len, dir, bad);
        hi  = 0;
        len = 0;
        write_enable = 1'b1;
        reg_addr     = 16'd0;
        reg_data     = 16'd20;
        duty_in      = 16'd8;
        do begin
            hi += int'(pwm_out);
            len++;
            @(negedge clock);
            write_enable = 1'b0;
        end while (!period_start && len < 200);
        check("t5_cur_hi",  hi,  4);
        check("t5_cur_len", len, 10);
        measure(hi, len, dir, bad);
        check("t5_next_hi",  hi,  8);
        check("t5_next_len", len, 20);

        // PERIOD written on the wrap edge itself: old value for one more period.
        repeat (19) @(negedge clock);
        write_reg(16'd0, 16'd6);
        measure(hi, len, dir, bad);
        check("wrapwr_old_len", len, 20);
        measure(hi, len, dir, bad);
        check("wrapwr_new_len", len, 6);

        // Re-enable mid-period: write at cnt=1 drives high from cnt=3.
        write_reg(16'd2, 16'd0);
        write_reg(16'd0, 16'd10);
        duty_in = 16'd6;
        measure(hi, len, dir, bad);
        measure(hi, len, dir, bad);
        hi  = 0;
        len = 0;
        do begin
            hi += int'(pwm_out);
            len++;
            @(negedge clock);
            if (len == 1) begin
                write_enable = 1'b1;
                reg_addr     = 16'd2;
                reg_data     = 16'd1;
            end else begin
                write_enable = 1'b0;
            end
        end while (!period_start && len < 200);
        check("reen_hi",  hi,  3);
        check("reen_len", len, 10);

        // dir_invert applies from the edge after the write.
        duty_in = 16'hFFFD;
        measure(hi, len, dir, bad);
        measure(hi, len, dir, bad);
        check("inv_before", int'(dir_out), 1);
        write_reg(16'd2, 16'd3);
        check("inv_write_edge", int'(dir_out), 1);
        @(negedge clock);
        check("inv_after", int'(dir_out), 0);

        // Asynchronous reset during the high part of a period.
        write_reg(16'd2, 16'd1);
        measure(hi, len, dir, bad);
        measure(hi, len, dir, bad);
        @(negedge clock);
        check("pre_rst_pwm", int'(pwm_out), 1);
        reset = 1'b1;
        #1;
        check("t6_rst_pwm",   int'(pwm_out), 0);
        check("t6_rst_dir",   int'(dir_out), 0);
        check("t6_rst_start", int'(period_start), 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t6_p0_start", int'(period_start), 1);
            check("t6_p0_pwm",   int'(pwm_out), 0);
        end

        // CTRL was cleared by reset: PWM runs but stays low until enabled.
        duty_in = 16'd4;
        write_reg(16'd0, 16'd10);
        measure(hi, len, dir, bad);
        measure(hi, len, dir, bad);
        check("t6_ctrl_clr_hi",  hi,  0);
        check("t6_ctrl_clr_len", len, 10);
        write_reg(16'd2, 16'd1);
        measure(hi, len, dir, bad);
        measure(hi, len, dir, bad);
        check("t6_resume_hi", hi, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
